vga_frame_monitor: RTL and testbench
====================================

Name: vga_frame_monitor

Overview:
Receive-side counterpart of the system's VGA output port. It samples the VGA export signals (hs, vs, blank_n, r, g, b) back inside the FPGA and measures per-frame timing: line period, active pixels per line and active lines per frame. It also computes a 32-bit pixel checksum, flags deviations from the expected 640x480 format and publishes results once per frame. It sits beside the Nios system as a self-check / lab-verification block.

Parameters:
H_ACTIVE, 640, expected active (blank_n=1) pixels per line
V_ACTIVE, 480, expected lines per frame containing at least one active pixel
H_TOTAL, 800, expected pixel samples between consecutive hs falling edges
CW, 12, width of the h/v measurement counters

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
pix_en  in  1  pixel-sample enable; inputs are sampled only on clk edges where pix_en=1
vga_hs  in  1  horizontal sync, active-low
vga_vs  in  1  vertical sync, active-low
vga_blank_n  in  1  1 = active pixel
vga_r / vga_g / vga_b  in  8 each  pixel colour
frame_done  out  1  one-clk pulse when results are published
frame_cnt  out  16  count of published frames, wraps at 2^16
htot_meas  out  CW  last complete line period in samples
hact_meas  out  CW  active-pixel count of the last non-empty line
vact_meas  out  CW  active-line count of the last frame
checksum  out  32  sum mod 2^32 of zero-extended {r,g,b} over active pixels of the last frame
err_hact / err_vact / err_htot  out  1 each  error flags for the last published frame
locked  out  1  1 after 2 consecutive error-free published frames

Behaviour:
- Reset: all outputs 0; state SEEK; internal counters, accumulators and sticky flags cleared; previous-sample registers set to hs=1, vs=1. Reset mid-frame discards partial data, and the next published frame requires a fresh vs falling edge after SEEK.
- Sample register: on pix_en, capture inputs into s1 and shift old s1 into s2. An edge is a falling edge when s2=1 and s1=0. All logic below advances only on pix_en cycles; outputs hold otherwise.
- States:
  - SEEK: ignore data. On a vs falling edge go to FRAME and clear the frame accumulators.
  - FRAME: count and check as below. On a vs falling edge, publish and remain in FRAME with accumulators cleared.
- Line counting (FRAME):
  - h_cnt increments per sample and saturates at 2^CW-1.
  - On an hs falling edge, compare h_cnt against H_TOTAL. The first edge of a frame is not compared.
  - On each active sample (blank_n=1): a_cnt++ (saturating), and checksum_acc += {r,g,b}.
  - At each hs falling edge with a_cnt>0: set sticky err_hact if a_cnt != H_ACTIVE, increment line counter, latch a_cnt into hact shadow, clear a_cnt. Lines with a_cnt=0 are not checked or counted.
  - A mismatched line period sets sticky err_htot, and h_cnt restarts at 1 on the edge sample.
- Publish: in the clk cycle after the sample holding the vs falling edge, frame_done=1 for exactly one clk.
  - Same cycle: htot_meas, hact_meas, vact_meas, checksum and err_* load from the accumulators and sticky flags; err_vact = (lines != V_ACTIVE); frame_cnt++.
  - The first vs edge out of SEEK does not publish.
- Simultaneous hs and vs falling edges in one sample: close the line first (its checks and count are included in the frame), then publish.
- locked: a good-frame counter (0..2) increments on each error-free publish and clears on any errored publish. locked = (counter==2), updated with frame_done.
- Latency: 2 clk from vga_vs low presented with pix_en to the frame_done pulse. Each output is stable until the next publish.

Test Plan:
- Three clean 800x525 frames, 640x480 active, constant pixel 0x010203, pix_en every 2nd clk -> first frame_done at the 2nd vs edge; checksum=0xB96E1000, hact=640, vact=480, htot=800, no errors; locked=1 after the 2nd publish.
- Line 100 carries 639 active pixels -> err_hact=1 for that frame only, locked drops to 0, and the next clean frame clears err_hact.
- Frame with 479 active lines -> vact_meas=479, err_vact=1, err_hact=0.
- One line period of 799 samples -> err_htot=1, and htot_meas reflects the last line (800).
- Reset asserted mid-frame for 1 clk -> all outputs 0; the next vs edge publishes nothing; the following edge publishes correctly with frame_cnt=1.
- hs and vs fall on the same sample with that line active -> the line is counted (vact=480) and frame_done follows 2 clk later.

Source files
------------

// File: rtl/vga_frame_monitor.sv
// vga_frame_monitor: samples VGA export pins and publishes per-frame timing, checksum and error flags
module vga_frame_monitor #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int H_TOTAL  = 800,
    parameter int CW       = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pix_en,
    input  logic          vga_hs,
    input  logic          vga_vs,
    input  logic          vga_blank_n,
    input  logic [7:0]    vga_r,
    input  logic [7:0]    vga_g,
    input  logic [7:0]    vga_b,
    output logic          frame_done,
    output logic [15:0]   frame_cnt,
    output logic [CW-1:0] htot_meas,
    output logic [CW-1:0] hact_meas,
    output logic [CW-1:0] vact_meas,
    output logic [31:0]   checksum,
    output logic          err_hact,
    output logic          err_vact,
    output logic          err_htot,
    output logic          locked
);
    localparam logic [CW-1:0] HA   = CW'(H_ACTIVE);
    localparam logic [CW-1:0] VA   = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HT   = CW'(H_TOTAL);
    localparam logic [CW-1:0] CMAX = '1;
    typedef enum logic {SEEK, FRAME} state_t;
    state_t state, state_nx;
    logic s1_hs, s1_vs, s1_bl, s2_hs, s2_vs, v1;
    logic [23:0] s1_rgb;
    logic [CW-1:0] h_cnt, a_cnt, lines, htot_sh, hact_sh;
    logic [CW-1:0] nx_lines, nx_htot, nx_hact;
    logic [31:0] acc, pix;
    logic e_hact, e_htot, first;
    logic hs_fall, vs_fall, close, chk, nx_ehact, nx_ehtot, nx_evact, publish, restart;
    logic [1:0] good, nx_good;

    // capture pins on pix_en; v1 marks the following clk, where that sample is processed
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_hs  <= 1'b1;
            s1_vs  <= 1'b1;
            s1_bl  <= 1'b0;
            s1_rgb <= '0;
            s2_hs  <= 1'b1;
            s2_vs  <= 1'b1;
            v1     <= 1'b0;
        end else begin
            v1 <= pix_en;
            if (pix_en) begin
                s1_hs  <= vga_hs;
                s1_vs  <= vga_vs;
                s1_bl  <= vga_blank_n;
                s1_rgb <= {vga_r, vga_g, vga_b};
                s2_hs  <= s1_hs;
                s2_vs  <= s1_vs;
            end
        end
    end

    // edges and the accumulator values after this sample closes any line it ends
    always_comb begin
        hs_fall  = s2_hs & ~s1_hs;
        vs_fall  = s2_vs & ~s1_vs;
        pix      = s1_bl ? {8'd0, s1_rgb} : 32'd0;
        close    = hs_fall && a_cnt != '0;
        chk      = hs_fall && !first;
        nx_lines = (close && lines != CMAX) ? lines + 1'b1 : lines;
        nx_hact  = close ? a_cnt : hact_sh;
        nx_htot  = chk ? h_cnt : htot_sh;
        nx_ehact = e_hact | (close && a_cnt != HA);
        nx_ehtot = e_htot | (chk && h_cnt != HT);
        nx_evact = nx_lines != VA;
        nx_good  = (nx_ehact || nx_ehtot || nx_evact) ? 2'd0 : (good == 2'd2 ? 2'd2 : good + 2'd1);
    end

    // state register
    always_ff @(posedge clk) state <= reset ? SEEK : state_nx;

    // any processed vs edge opens a frame
    always_comb state_nx = (v1 && vs_fall) ? FRAME : state;

    // restart clears frame accumulators; only a vs edge inside FRAME publishes
    always_comb begin
        restart = v1 && vs_fall;
        publish = restart && state == FRAME;
    end

    // line period counter restarts at 1 on every hs edge sample
    always_ff @(posedge clk) begin
        if (reset) h_cnt <= '0;
        else if (v1) h_cnt <= hs_fall ? CW'(1) : (h_cnt == CMAX ? h_cnt : h_cnt + 1'b1);
    end

    // frame accumulators; the edge sample's own pixel belongs to the new line/frame
    always_ff @(posedge clk) begin
        if (reset) begin
            a_cnt   <= '0;
            lines   <= '0;
            acc     <= '0;
            e_hact  <= 1'b0;
            e_htot  <= 1'b0;
            htot_sh <= '0;
            hact_sh <= '0;
            first   <= 1'b1;
        end else if (v1 && (state == FRAME || vs_fall)) begin
            a_cnt   <= (hs_fall || state == SEEK) ? {{(CW-1){1'b0}}, s1_bl} :
                       ((s1_bl && a_cnt != CMAX) ? a_cnt + 1'b1 : a_cnt);
            first   <= vs_fall | (first & ~hs_fall);
            htot_sh <= nx_htot;
            hact_sh <= nx_hact;
            lines   <= restart ? '0 : nx_lines;
            e_hact  <= restart ? 1'b0 : nx_ehact;
            e_htot  <= restart ? 1'b0 : nx_ehtot;
            acc     <= restart ? pix : acc + pix;
        end
    end

    // publish results in the clk after the vs-edge sample
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_done <= 1'b0;
            frame_cnt  <= '0;
            htot_meas  <= '0;
            hact_meas  <= '0;
            vact_meas  <= '0;
            checksum   <= '0;
            err_hact   <= 1'b0;
            err_vact   <= 1'b0;
            err_htot   <= 1'b0;
            locked     <= 1'b0;
            good       <= '0;
        end else begin
            frame_done <= publish;
            if (publish) begin
                frame_cnt <= frame_cnt + 16'd1;
                htot_meas <= nx_htot;
                hact_meas <= nx_hact;
                vact_meas <= nx_lines;
                checksum  <= acc;
                err_hact  <= nx_ehact;
                err_vact  <= nx_evact;
                err_htot  <= nx_ehtot;
                good      <= nx_good;
                locked    <= nx_good == 2'd2;
            end
        end
    end
endmodule

// File: tb/tb_vga_frame_monitor.sv
// tb_vga_frame_monitor: random VGA line streams against a line-record frame model
module tb_vga_frame_monitor;
    localparam int HA = 16;
    localparam int VA = 6;
    localparam int HT = 24;
    localparam int CW = 12;
    logic clk = 0, reset = 1, pix_en = 0, hs = 1, vs = 1, bl = 0;
    logic [7:0] r = 0, g = 0, b = 0;
    logic frame_done, err_hact, err_vact, err_htot, locked;
    logic [15:0] frame_cnt;
    logic [CW-1:0] htot_meas, hact_meas, vact_meas;
    logic [31:0] checksum;

    vga_frame_monitor #(.H_ACTIVE(HA), .V_ACTIVE(VA), .H_TOTAL(HT), .CW(CW)) dut (
        .clk(clk), .reset(reset), .pix_en(pix_en), .vga_hs(hs), .vga_vs(vs), .vga_blank_n(bl),
        .vga_r(r), .vga_g(g), .vga_b(b), .frame_done(frame_done), .frame_cnt(frame_cnt),
        .htot_meas(htot_meas), .hact_meas(hact_meas), .vact_meas(vact_meas), .checksum(checksum),
        .err_hact(err_hact), .err_vact(err_vact), .err_htot(err_htot), .locked(locked)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {int len; int act; logic [31:0] sum;} line_t;
    typedef struct {int due; logic [31:0] fc, htot, hact, vact, sum; logic eh, ev, et, lk;} want_t;
    line_t cur[$];
    want_t want_q[$];
    int n_tests = 0, n_fail = 0, gap = 2, vs_rem = 0;
    bit m_frame = 0;
    int m_fc = 0, m_good = 0, m_htot = 0, m_hact = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%0h want=%0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    task automatic chk_zero();
        chk("z_done", {31'd0, frame_done}, 0);
        chk("z_fcnt", {16'd0, frame_cnt}, 0);
        chk("z_htot", {20'd0, htot_meas}, 0);
        chk("z_hact", {20'd0, hact_meas}, 0);
        chk("z_vact", {20'd0, vact_meas}, 0);
        chk("z_sum", checksum, 0);
        chk("z_ehact", {31'd0, err_hact}, 0);
        chk("z_evact", {31'd0, err_vact}, 0);
        chk("z_ehtot", {31'd0, err_htot}, 0);
        chk("z_locked", {31'd0, locked}, 0);
    endtask

    // a frame spans the lines from one vs line up to (not incl.) the next;
    // the edge opening line 0 of that span is not a measured period
    task automatic model_vs(input int due);
        want_t w;
        if (!m_frame) m_frame = 1;
        else begin
            w.due = due; w.sum = 0; w.vact = 0; w.eh = 0; w.et = 0;
            w.hact = m_hact; w.htot = m_htot;
            foreach (cur[k]) begin
                w.sum += cur[k].sum;
                if (cur[k].act > 0) begin
                    w.vact++;
                    w.hact = cur[k].act;
                    if (cur[k].act != HA) w.eh = 1;
                end
                if (k > 0) begin
                    w.htot = cur[k].len;
                    if (cur[k].len != HT) w.et = 1;
                end
            end
            w.ev = (w.vact != VA);
            m_good = (w.eh || w.ev || w.et) ? 0 : (m_good < 2 ? m_good + 1 : 2);
            w.lk = (m_good == 2);
            m_fc = (m_fc + 1) % 65536;
            w.fc = m_fc;
            m_hact = w.hact;
            m_htot = w.htot;
            want_q.push_back(w);
        end
        cur.delete();
    endtask

    task automatic model_reset();
        m_frame = 0; m_fc = 0; m_good = 0; m_htot = 0; m_hact = 0;
        cur.delete();
    endtask

    task automatic drive(input logic h, input logic v, input logic a, input logic [23:0] c);
        hs = h; vs = v; bl = a; {r, g, b} = c; pix_en = 1;
        @(negedge clk);
        pix_en = 0;
        repeat (gap - 1) @(negedge clk);
    endtask

    // hs low at offsets 0..3, active pixels from offset 6; vo>=0 puts the vs fall in this line
    task automatic emit_line(input int len, input int act, input bit konst, input int vo, input int rat);
        line_t ln;
        logic [23:0] col;
        ln.len = len; ln.act = act; ln.sum = 0;
        for (int s = 0; s < len; s++) begin
            if (s == rat) begin
                reset = 1; pix_en = 0;
                @(negedge clk);
                reset = 0;
                chk_zero();
                model_reset();
            end
            if (s == vo) begin
                model_vs(cyc + 2);
                vs_rem = len - vo + HT;
            end
            col = konst ? 24'h010203 : 24'($urandom);
            if (s >= 6 && s < 6 + act) ln.sum += {8'd0, col};
            drive(s >= 4, vs_rem == 0, s >= 6 && s < 6 + act, col);
            if (vs_rem > 0) vs_rem--;
        end
        cur.push_back(ln);
    endtask

    task automatic emit_frame(input int nact, input int bad_l, input int bad_a, input int short_l,
                              input int vsl, input int vo, input int rst_l, input bit konst);
        for (int l = 0; l < nact + 4; l++)
            emit_line(l == short_l ? HT - 1 : HT, l < nact ? (l == bad_l ? bad_a : HA) : 0,
                      konst, l == nact + vsl ? vo : -1, l == rst_l ? 10 : -1);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (frame_done) begin
                if (want_q.size() == 0) chk("spurious_done", 1, 0);
                else begin
                    want_t w;
                    w = want_q.pop_front();
                    chk("done_cyc", cyc, w.due);
                    chk("frame_cnt", {16'd0, frame_cnt}, w.fc);
                    chk("htot", {20'd0, htot_meas}, w.htot);
                    chk("hact", {20'd0, hact_meas}, w.hact);
                    chk("vact", {20'd0, vact_meas}, w.vact);
                    chk("checksum", checksum, w.sum);
                    chk("err_hact", {31'd0, err_hact}, {31'd0, w.eh});
                    chk("err_vact", {31'd0, err_vact}, {31'd0, w.ev});
                    chk("err_htot", {31'd0, err_htot}, {31'd0, w.et});
                    chk("locked", {31'd0, locked}, {31'd0, w.lk});
                end
            end else if (want_q.size() > 0 && cyc > want_q[0].due) begin
                chk("done_missing", cyc, want_q[0].due);
                void'(want_q.pop_front());
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        reset = 0;
        chk_zero();
        gap = 2;
        for (int f = 0; f < 3; f++) emit_frame(VA, -1, 0, -1, 2, $urandom_range(1, 3), -1, 1);
        gap = $urandom_range(1, 2);
        emit_frame(VA, 2, HA - 1, -1, 2, $urandom_range(1, 3), -1, 0);
        emit_frame(VA, -1, 0, -1, 2, $urandom_range(1, 3), -1, 0);
        emit_frame(VA - 1, -1, 0, -1, 2, $urandom_range(1, 3), -1, 0);
        gap = $urandom_range(1, 2);
        emit_frame(VA, -1, 0, 3, 2, $urandom_range(1, 3), -1, 0);
        emit_frame(VA, -1, 0, -1, 2, $urandom_range(1, 3), -1, 0);
        emit_frame(VA, -1, 0, -1, 0, 0, -1, 0);
        emit_frame(VA, -1, 0, -1, 2, 1, -1, 0);
        emit_frame(VA, -1, 0, -1, 2, 2, 2, 0);
        emit_frame(VA, -1, 0, -1, 2, 1, -1, 0);
        emit_frame(VA, -1, 0, -1, 2, 3, -1, 0);
        for (int f = 0; f < 5; f++) begin
            gap = $urandom_range(1, 2);
            emit_frame($urandom_range(VA - 1, VA + 1),
                       $urandom_range(0, 1) ? int'($urandom_range(0, VA - 2)) : -1,
                       $urandom_range(0, 1) ? HA - 1 : HA + 1,
                       $urandom_range(0, 2) == 0 ? int'($urandom_range(0, 7)) : -1,
                       $urandom_range(0, 2), $urandom_range(0, 3), -1, 0);
        end
        emit_line(HT, 0, 0, -1, -1);
        repeat (10) @(negedge clk);
        chk("pending", want_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
